pll_reconfig_seq: RTL and testbench

PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

---
 rtl/pll_reconfig_seq_if.sv | 20 ++
 rtl/pll_reconfig_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reconfig_seq_if.sv
// PLL reconfiguration management bus: write strobe/address/data toward the reconfig
// controller, its busy flag, PLL reset and lock status.
interface pll_reconfig_seq_if;
    logic        locked;
    logic        mgmt_waitrequest;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        pll_reset;

    modport master (
        input  locked, mgmt_waitrequest,
        output mgmt_write, mgmt_address, mgmt_writedata, pll_reset
    );

    modport slave (
        output locked, mgmt_waitrequest,
        input  mgmt_write, mgmt_address, mgmt_writedata, pll_reset
    );
endinterface

// File: rtl/pll_reconfig_seq.sv
// Steps a PLL reconfig controller through M/K/N/C/phase programming for the table entry at pos.
// Optional lock watchdog: define PLLSEQ_LOCK_TIMEOUT_EN.
module pll_reconfig_seq #(
    parameter int NUM_CFG     = 11,
    parameter int NUM_CNT     = 2,
    parameter int STEP_GAP    = 8,
    parameter int PH_BASE     = 29,
    parameter int PH_MAX      = 100,
    parameter int TIMEOUT_CYC = 5000000,
    localparam int PW = $clog2(NUM_CFG)
) (
    input  logic                CLK_50M,
    input  logic                RESET,
    pll_reconfig_seq_if.master  mgmt,
    input  logic                cmd_up,
    input  logic                cmd_down,
    input  logic                cmd_auto,
    input  logic                cmd_reapply,
    input  logic                cmd_ph_inc,
    input  logic                cmd_ph_dec,
    input  logic                fail,
    input  logic [31:0]         cfg_m,
    input  logic [31:0]         cfg_k,
    input  logic [31:0]         cfg_c,
    input  logic [31:0]         cfg_ph,
    output logic [PW-1:0]       pos,
    output logic [7:0]          phase,
    output logic                busy,
    output logic                auto_mode,
    output logic                ph_mode,
    output logic                lock_err
);
    localparam int GW = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
    localparam int CW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_MODE, S_M, S_K, S_N, S_C, S_CP, S_BW, S_APPLY,
        S_RST1, S_RST0, S_MODE2, S_PHASE, S_APPLY2, S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [GW-1:0] gap, gap_nx;
    logic [CW-1:0] ci, ci_nx;
    logic [PW-1:0] pos_nx;
    logic [7:0]    phase_cmd, phase_nx;
    logic          busy_nx, auto_nx, phm_nx;
    logic          wr, wr_nx, prst, prst_nx;
    logic [5:0]    addr, addr_nx;
    logic [31:0]   data, data_nx, ph_delta;
    logic          cmd_acc, start, go, rst0_step, wd_fire;

    logic unused_bits;
    assign unused_bits = ^{1'b0, cfg_ph[31:8]};

    assign mgmt.mgmt_write     = wr;
    assign mgmt.mgmt_address   = addr;
    assign mgmt.mgmt_writedata = data;
    assign mgmt.pll_reset      = prst;

    // Only the highest-priority pulse is considered; if its bound fails the whole cycle is a no-op.
    always_comb begin
        cmd_acc   = 1'b0;
        pos_nx    = pos;
        phase_cmd = phase;
        auto_nx   = auto_mode;
        phm_nx    = ph_mode;
        if (cmd_auto) begin
            cmd_acc = 1'b1; pos_nx = '0; auto_nx = 1'b1; phm_nx = 1'b0;
        end else if (cmd_reapply) begin
            cmd_acc = 1'b1; auto_nx = 1'b0;
        end else if (cmd_down) begin
            if (pos < PW'(NUM_CFG - 1)) begin
                cmd_acc = 1'b1; pos_nx = pos + 1'b1; auto_nx = 1'b0; phm_nx = 1'b0;
            end
        end else if (cmd_up) begin
            if (pos > '0) begin
                cmd_acc = 1'b1; pos_nx = pos - 1'b1; auto_nx = 1'b0; phm_nx = 1'b0;
            end
        end else if (cmd_ph_inc) begin
            if (phase < 8'(PH_MAX)) begin
                cmd_acc = 1'b1; phase_cmd = phase + 8'd1; auto_nx = 1'b0; phm_nx = 1'b1;
            end
        end else if (cmd_ph_dec) begin
            if (phase > 8'd0) begin
                cmd_acc = 1'b1; phase_cmd = phase - 8'd1; auto_nx = 1'b0; phm_nx = 1'b1;
            end
        end
        start = cmd_acc;
        if (!cmd_acc && auto_mode && fail && !busy && pos < PW'(NUM_CFG - 1)) begin
            start  = 1'b1;
            pos_nx = pos + 1'b1;
        end
    end

    always_comb begin
        if (phase > 8'(PH_BASE))
            ph_delta = 32'(phase - 8'(PH_BASE));
        else
            ph_delta = 32'(8'(PH_BASE) - phase) | 32'h0020_0000;
    end

    assign go = (gap == '0) && ((mgmt.locked && !mgmt.mgmt_waitrequest) || prst);

    always_comb begin
        state_nx  = state;
        gap_nx    = (gap != '0) ? gap - 1'b1 : gap;
        ci_nx     = ci;
        phase_nx  = phase_cmd;
        busy_nx   = busy;
        wr_nx     = 1'b0;
        addr_nx   = addr;
        data_nx   = data;
        prst_nx   = prst;
        rst0_step = 1'b0;
        if (start) begin
            state_nx = S_MODE;
            gap_nx   = GW'(STEP_GAP - 1);
            ci_nx    = '0;
            busy_nx  = 1'b1;
            prst_nx  = 1'b0;
        end else if (wd_fire) begin
            state_nx = S_IDLE;
            busy_nx  = 1'b0;
        end else if (state != S_IDLE && go) begin
            gap_nx = GW'(STEP_GAP - 1);
            unique case (state)
                S_MODE: begin
                    wr_nx = 1'b1; addr_nx = 6'd0; data_nx = 32'd0; state_nx = S_M;
                    if (!ph_mode) phase_nx = cfg_ph[7:0];
                end
                S_M:     begin wr_nx = 1'b1; addr_nx = 6'd4; data_nx = cfg_m;        state_nx = S_K;  end
                S_K:     begin wr_nx = 1'b1; addr_nx = 6'd7; data_nx = cfg_k;        state_nx = S_N;  end
                S_N:     begin wr_nx = 1'b1; addr_nx = 6'd3; data_nx = 32'h0001_0000; state_nx = S_C; end
                S_C: begin
                    wr_nx = 1'b1; addr_nx = 6'd5; data_nx = cfg_c | (32'(ci) << 18);
                    if (ci == CW'(NUM_CNT - 1)) state_nx = S_CP;
                    else ci_nx = ci + 1'b1;
                end
                S_CP:    begin wr_nx = 1'b1; addr_nx = 6'd9; data_nx = 32'd1; state_nx = S_BW;    end
                S_BW:    begin wr_nx = 1'b1; addr_nx = 6'd8; data_nx = 32'd7; state_nx = S_APPLY; end
                S_APPLY: begin wr_nx = 1'b1; addr_nx = 6'd2; data_nx = 32'd0; state_nx = S_RST1;  end
                S_RST1:  begin prst_nx = 1'b1; state_nx = S_RST0; end
                S_RST0: begin
                    prst_nx   = 1'b0;
                    rst0_step = 1'b1;
                    state_nx  = (phase == 8'(PH_BASE)) ? S_DONE : S_MODE2;
                end
                S_MODE2: begin wr_nx = 1'b1; addr_nx = 6'd0; data_nx = 32'd0; state_nx = S_PHASE; end
                S_PHASE: begin
                    wr_nx = 1'b1; addr_nx = 6'd6; data_nx = ph_delta | 32'h0001_0000; state_nx = S_APPLY2;
                end
                S_APPLY2: begin wr_nx = 1'b1; addr_nx = 6'd2; data_nx = 32'd0; state_nx = S_DONE; end
                S_DONE:   begin busy_nx = 1'b0; state_nx = S_IDLE; end
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            state     <= S_IDLE;
            gap       <= '0;
            ci        <= '0;
            pos       <= '0;
            phase     <= '0;
            busy      <= 1'b0;
            auto_mode <= 1'b0;
            ph_mode   <= 1'b0;
            wr        <= 1'b0;
            addr      <= '0;
            data      <= '0;
            prst      <= 1'b0;
        end else begin
            state     <= state_nx;
            gap       <= gap_nx;
            ci        <= ci_nx;
            pos       <= pos_nx;
            phase     <= phase_nx;
            busy      <= busy_nx;
            auto_mode <= auto_nx;
            ph_mode   <= phm_nx;
            wr        <= wr_nx;
            addr      <= addr_nx;
            data      <= data_nx;
            prst      <= prst_nx;
        end
    end

`ifdef PLLSEQ_LOCK_TIMEOUT_EN
    logic        wd_act;
    logic [31:0] wd_cnt;

    assign wd_fire = wd_act && !mgmt.locked && (wd_cnt == 32'(TIMEOUT_CYC - 1));

    // Armed by RST0, disarmed by the first locked sample or by a restart.
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            wd_act   <= 1'b0;
            wd_cnt   <= '0;
            lock_err <= 1'b0;
        end else begin
            if (start || mgmt.locked || wd_fire) begin
                wd_act <= 1'b0;
            end else if (rst0_step) begin
                wd_act <= 1'b1;
                wd_cnt <= '0;
            end else if (wd_act) begin
                wd_cnt <= wd_cnt + 32'd1;
            end
            if (cmd_acc)      lock_err <= 1'b0;
            else if (wd_fire) lock_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0) & rst0_step;
    assign wd_fire  = 1'b0;
    assign lock_err = 1'b0;
`endif
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Randomised + directed bench for pll_reconfig_seq against a write-list reference model.
module tb_pll_reconfig_seq;
    localparam int NC  = 11;
    localparam int NCN = 2;
    localparam int PB  = 29;
    localparam int PM  = 100;
    localparam int TO  = 200;

    logic        clk, RESET;
    logic        cmd_up, cmd_down, cmd_auto, cmd_reapply, cmd_ph_inc, cmd_ph_dec, fail;
    logic [31:0] cfg_m, cfg_k, cfg_c, cfg_ph;
    logic [3:0]  pos;
    logic [7:0]  phase;
    logic        busy, auto_mode, ph_mode, lock_err;

    logic [31:0] tm [NC];
    logic [31:0] tk [NC];
    logic [31:0] tc [NC];
    logic [31:0] tp [NC];

    pll_reconfig_seq_if mif ();

    pll_reconfig_seq #(.NUM_CFG(NC), .NUM_CNT(NCN), .STEP_GAP(8), .PH_BASE(PB),
                       .PH_MAX(PM), .TIMEOUT_CYC(TO)) dut (
        .CLK_50M(clk), .RESET(RESET), .mgmt(mif.master),
        .cmd_up(cmd_up), .cmd_down(cmd_down), .cmd_auto(cmd_auto),
        .cmd_reapply(cmd_reapply), .cmd_ph_inc(cmd_ph_inc), .cmd_ph_dec(cmd_ph_dec),
        .fail(fail), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_c(cfg_c), .cfg_ph(cfg_ph),
        .pos(pos), .phase(phase), .busy(busy), .auto_mode(auto_mode),
        .ph_mode(ph_mode), .lock_err(lock_err)
    );

    assign cfg_m  = tm[pos];
    assign cfg_k  = tk[pos];
    assign cfg_c  = tc[pos];
    assign cfg_ph = tp[pos];

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int m_pos, m_phase;
    bit m_auto, m_phm, m_lerr;
    bit jitter;
    logic [37:0] wq [$];
    logic [37:0] expq [$];
    int  rst_pulses;
    bit  rst_prev;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Bus monitor and controller-busy jitter.
    initial begin
        rst_prev = 1'b0;
        rst_pulses = 0;
        forever begin
            @(negedge clk);
            if (mif.mgmt_write) wq.push_back({mif.mgmt_address, mif.mgmt_writedata});
            if (mif.pll_reset && !rst_prev) rst_pulses++;
            rst_prev = mif.pll_reset;
        end
    end

    initial begin
        mif.mgmt_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            mif.mgmt_waitrequest = jitter && ($urandom_range(0, 3) == 0);
        end
    end

    // Returns 1 when the command is accepted; 0=auto 1=reapply 2=down 3=up 4=ph_inc 5=ph_dec.
    function automatic bit model_cmd(input int c);
        bit acc;
        acc = 1'b0;
        case (c)
            0: begin acc = 1; m_pos = 0; m_auto = 1; m_phm = 0; end
            1: begin acc = 1; m_auto = 0; end
            2: if (m_pos < NC - 1) begin acc = 1; m_pos++; m_auto = 0; m_phm = 0; end
            3: if (m_pos > 0) begin acc = 1; m_pos--; m_auto = 0; m_phm = 0; end
            4: if (m_phase < PM) begin acc = 1; m_phase++; m_auto = 0; m_phm = 1; end
            5: if (m_phase > 0) begin acc = 1; m_phase--; m_auto = 0; m_phm = 1; end
            default: acc = 0;
        endcase
        if (acc) m_lerr = 0;
        return acc;
    endfunction

    function automatic void add_exp(input int p, input int ph);
        int d;
        expq.push_back({6'd0, 32'd0});
        expq.push_back({6'd4, tm[p]});
        expq.push_back({6'd7, tk[p]});
        expq.push_back({6'd3, 32'h10000});
        for (int i = 0; i < NCN; i++) expq.push_back({6'd5, tc[p] | (32'(i) << 18)});
        expq.push_back({6'd9, 32'd1});
        expq.push_back({6'd8, 32'd7});
        expq.push_back({6'd2, 32'd0});
        if (ph != PB) begin
            d = (ph > PB) ? (ph - PB) : ((PB - ph) | 'h200000);
            expq.push_back({6'd0, 32'd0});
            expq.push_back({6'd6, 32'(d) | 32'h10000});
            expq.push_back({6'd2, 32'd0});
        end
    endfunction

    task automatic cmp_writes(input string tag);
        check({tag, "_len"}, 64'(wq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < wq.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 64'(wq[i]), 64'(expq[i]));
    endtask

    task automatic pulse(input int c);
        case (c)
            0: cmd_auto = 1'b1;
            1: cmd_reapply = 1'b1;
            2: cmd_down = 1'b1;
            3: cmd_up = 1'b1;
            4: cmd_ph_inc = 1'b1;
            default: cmd_ph_dec = 1'b1;
        endcase
        @(negedge clk);
        {cmd_auto, cmd_reapply, cmd_down, cmd_up, cmd_ph_inc, cmd_ph_dec} = '0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin @(negedge clk); n++; end
        check({tag, "_done_in_budget"}, 64'(n < budget), 64'd1);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pos"}, 64'(pos), 64'(m_pos));
        check({tag, "_phase"}, 64'(phase), 64'(m_phase));
        check({tag, "_auto"}, 64'(auto_mode), 64'(m_auto));
        check({tag, "_phm"}, 64'(ph_mode), 64'(m_phm));
        check({tag, "_lerr"}, 64'(lock_err), 64'(m_lerr));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_cmd(input string tag, input int c);
        bit acc;
        acc = model_cmd(c);
        wq.delete();
        rst_pulses = 0;
        pulse(c);
        if (acc) begin
            check({tag, "_busy_hi"}, 64'(busy), 64'd1);
            wait_idle(tag, 4000);
            if (!m_phm) m_phase = int'(tp[m_pos][7:0]);
            expq.delete();
            add_exp(m_pos, m_phase);
            cmp_writes(tag);
            check({tag, "_rst_pulse"}, 64'(rst_pulses), 64'd1);
        end else begin
            repeat (100) @(negedge clk);
            check({tag, "_ignored_writes"}, 64'(wq.size()), 64'd0);
        end
        check_state(tag);
    endtask

    initial begin
        int n, c;
        bit acc;
        RESET = 1'b1;
        {cmd_auto, cmd_reapply, cmd_down, cmd_up, cmd_ph_inc, cmd_ph_dec} = '0;
        fail = 1'b0;
        jitter = 1'b0;
        mif.locked = 1'b1;
        for (int i = 0; i < NC; i++) begin
            tm[i] = $urandom(); tk[i] = $urandom();
            tc[i] = $urandom() & 32'h0003_FFFF;
            tp[i] = 32'($urandom_range(0, PM));
        end
        tp[0] = 29; tp[1] = 29; tp[2] = 20; tp[4] = 95; tp[5] = 0;
        m_pos = 0; m_phase = 0; m_auto = 0; m_phm = 0; m_lerr = 0;
        repeat (3) @(negedge clk);
        check("reset_outs", {pos, phase, busy, auto_mode, ph_mode, lock_err, mif.mgmt_write,
              mif.mgmt_address, mif.mgmt_writedata, mif.pll_reset}, 64'd0);
        RESET = 1'b0;
        @(negedge clk);
        check_state("post_reset");

        run_cmd("down_ph29", 2);
        check("down_ph29_c1", 64'(wq.size() > 5 ? wq[5] : 38'd0), 64'({6'd5, tc[1] | 32'h40000}));
        run_cmd("up0", 3);
        run_cmd("reapply0", 1);
        for (int i = 0; i < 3; i++) run_cmd($sformatf("inc%0d", i), 4);
        check("inc3_phase", 64'(phase), 64'd32);
        check("inc3_phase_wr", 64'(wq.size() > 10 ? wq[10] : 38'd0), 64'({6'd6, 32'h10003}));
        run_cmd("up_at_0", 3);
        run_cmd("down_to1", 2);
        run_cmd("down_to2", 2);
        run_cmd("reapply20", 1);
        check("reapply20_wr", 64'(wq.size() > 10 ? wq[10] : 38'd0), 64'({6'd6, 32'h210009}));

        // Restart while the K write is still pending.
        acc = model_cmd(2);
        wq.delete();
        pulse(2);
        n = 0;
        while (wq.size() < 2 && n < 500) begin @(negedge clk); n++; end
        check("midk_m_wr", 64'(wq.size() > 1 ? wq[1] : 38'd0), 64'({6'd4, tm[3]}));
        run_cmd("midk_restart", 2);

        for (int i = 0; i < 6; i++) run_cmd($sformatf("inc_hi%0d", i), 4);
        run_cmd("inc_at_max", 4);
        run_cmd("down_to5", 2);
        run_cmd("dec_at_0", 5);

        // Lock lost across the PLL reset pulse.
        acc = model_cmd(1);
        wq.delete();
        pulse(1);
        n = 0;
        while (!mif.pll_reset && n < 2000) begin @(negedge clk); n++; end
        mif.locked = 1'b0;
        while (mif.pll_reset && n < 2000) begin @(negedge clk); n++; end
        check("lock_rst_seen", 64'(n < 2000), 64'd1);
        repeat (TO + 100) @(negedge clk);
        m_phase = int'(tp[m_pos][7:0]);
`ifdef PLLSEQ_LOCK_TIMEOUT_EN
        check("lock_to_busy", 64'(busy), 64'd0);
        check("lock_to_err", 64'(lock_err), 64'd1);
        check("lock_to_writes", 64'(wq.size()), 64'd9);
        m_lerr = 1;
        mif.locked = 1'b1;
        check_state("lock_to");
        run_cmd("lock_clear", 1);
`else
        check("lock_wait_busy", 64'(busy), 64'd1);
        check("lock_wait_err", 64'(lock_err), 64'd0);
        mif.locked = 1'b1;
        wait_idle("lock_wait", 4000);
        expq.delete();
        add_exp(m_pos, m_phase);
        cmp_writes("lock_wait");
        check_state("lock_wait");
`endif

        jitter = 1'b1;
        for (int i = 0; i < 25; i++) begin
            c = $urandom_range(1, 5);
            run_cmd($sformatf("rnd%0d_c%0d", i, c), c);
        end

        // Auto sweep driven by a held failure flag.
        fail = 1'b1;
        acc = model_cmd(0);
        wq.delete();
        rst_pulses = 0;
        pulse(0);
        n = 0;
        while (!(pos == 4'(NC - 1) && !busy) && n < 20000) begin @(negedge clk); n++; end
        check("auto_in_budget", 64'(n < 20000), 64'd1);
        repeat (300) @(negedge clk);
        expq.delete();
        for (int p = 0; p < NC; p++) add_exp(p, int'(tp[p][7:0]));
        cmp_writes("auto");
        check("auto_rst_pulses", 64'(rst_pulses), 64'(NC));
        m_pos = NC - 1;
        m_phase = int'(tp[NC - 1][7:0]);
        fail = 1'b0;
        check_state("auto_end");
        run_cmd("down_at_max", 2);

        // Reset in the middle of a sequence, with a command pulse held during reset.
        acc = model_cmd(3);
        wq.delete();
        pulse(3);
        n = 0;
        while (wq.size() < 4 && n < 1000) begin @(negedge clk); n++; end
        RESET = 1'b1;
        cmd_down = 1'b1;
        @(negedge clk);
        check("midseq_reset_outs", {pos, phase, busy, auto_mode, ph_mode, lock_err, mif.mgmt_write,
              mif.mgmt_address, mif.mgmt_writedata, mif.pll_reset}, 64'd0);
        cmd_down = 1'b0;
        RESET = 1'b0;
        m_pos = 0; m_phase = 0; m_auto = 0; m_phm = 0; m_lerr = 0;
        wq.delete();
        repeat (100) @(negedge clk);
        check("post_reset_writes", 64'(wq.size()), 64'd0);
        check_state("post_midseq_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
